// File: rtl/crotchet_sequencer.sv
// Tempo-driven crotchet sequencer: a frame-rate phase accumulator produces beat
// events that step through an optional count-in and then the crotchet play index.
module crotchet_sequencer #(
  parameter int PHASE_W        = 12,
  parameter int COUNT_IN_BEATS = 4,
  parameter int LAST_CROTCHET  = 103
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_pulse,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic               loop_en,
  input  logic [PHASE_W-1:0] tempo_inc,
  output logic [6:0]         crotchet,
  output logic               crotchet_pulse,
  output logic               count_in_pulse,
  output logic               running,
  output logic               done
);

  localparam int CNT_W = $clog2(COUNT_IN_BEATS + 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT_IN_BEATS);
  localparam logic [6:0]       CROT_LAST = 7'(LAST_CROTCHET);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COUNT_IN = 2'd1,
    ST_PLAY     = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [6:0]         crotchet_q, crotchet_d;
  logic               crotchet_pulse_q, crotchet_pulse_d;
  logic               count_in_pulse_q, count_in_pulse_d;
  logic               running_q, running_d;
  logic               done_q, done_d;
  logic [PHASE_W:0]   sum_s;
  logic               advance_s;

  // Next-state, accumulator, counters and pulse generation.
  always_comb begin
    state_d          = state_q;
    acc_d            = acc_q;
    cnt_d            = cnt_q;
    crotchet_d       = crotchet_q;
    crotchet_pulse_d = 1'b0;
    count_in_pulse_d = 1'b0;
    advance_s        = frame_pulse & ~pause;
    sum_s            = {1'b0, acc_q} + {1'b0, tempo_inc};

    if (stop) begin
      state_d    = ST_IDLE;
      acc_d      = '0;
      cnt_d      = '0;
      crotchet_d = 7'd0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            acc_d      = '0;
            cnt_d      = '0;
            crotchet_d = 7'd0;
            if (COUNT_IN_BEATS > 0) begin
              state_d = ST_COUNT_IN;
            end else begin
              state_d          = ST_PLAY;
              crotchet_pulse_d = 1'b1;
            end
          end else begin
            state_d = state_q;
          end
        end
        ST_COUNT_IN: begin
          if (advance_s) begin
            acc_d = sum_s[PHASE_W-1:0];
            // Carry out of the accumulator is the beat; the beat after the last count-in starts play.
            if (sum_s[PHASE_W] && (cnt_q == CNT_LAST)) begin
              state_d          = ST_PLAY;
              cnt_d            = '0;
              crotchet_d       = 7'd0;
              crotchet_pulse_d = 1'b1;
            end else if (sum_s[PHASE_W]) begin
              cnt_d            = cnt_q + CNT_W'(1);
              count_in_pulse_d = 1'b1;
            end else begin
              cnt_d = cnt_q;
            end
          end else begin
            acc_d = acc_q;
          end
        end
        ST_PLAY: begin
          if (advance_s) begin
            acc_d = sum_s[PHASE_W-1:0];
            if (sum_s[PHASE_W]) begin
              if (crotchet_q < CROT_LAST) begin
                crotchet_d       = crotchet_q + 7'd1;
                crotchet_pulse_d = 1'b1;
              end else if (loop_en) begin
                crotchet_d       = 7'd0;
                crotchet_pulse_d = 1'b1;
              end else begin
                state_d = ST_DONE;
              end
            end else begin
              crotchet_d = crotchet_q;
            end
          end else begin
            acc_d = acc_q;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          acc_d      = '0;
          cnt_d      = '0;
          crotchet_d = 7'd0;
        end
      endcase
    end

    running_d = (state_d == ST_COUNT_IN) || (state_d == ST_PLAY);
    done_d    = (state_d == ST_DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      acc_q            <= '0;
      cnt_q            <= '0;
      crotchet_q       <= 7'd0;
      crotchet_pulse_q <= 1'b0;
      count_in_pulse_q <= 1'b0;
      running_q        <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      acc_q            <= acc_d;
      cnt_q            <= cnt_d;
      crotchet_q       <= crotchet_d;
      crotchet_pulse_q <= crotchet_pulse_d;
      count_in_pulse_q <= count_in_pulse_d;
      running_q        <= running_d;
      done_q           <= done_d;
    end
  end

  assign crotchet       = crotchet_q;
  assign crotchet_pulse = crotchet_pulse_q;
  assign count_in_pulse = count_in_pulse_q;
  assign running        = running_q;
  assign done           = done_q;

endmodule

// File: doc/crotchet_sequencer.md
CROTCHET_SEQUENCER -- requirements
Module: crotchet_sequencer

Interface
REQ-001 SHALL have parameter PHASE_W, default 12, width of the tempo phase accumulator.
REQ-002 SHALL have parameter COUNT_IN_BEATS, default 4, count-in beats before play (0 = no count-in).
REQ-003 SHALL have parameter LAST_CROTCHET, default 103, final crotchet index (13 phrases x 8 - 1).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port frame_pulse  input  1  one-cycle pulse per video frame (vsync).
REQ-007 SHALL have port start  input  1  sampled level, begins sequence.
REQ-008 SHALL have port stop  input  1  sampled level, aborts to idle.
REQ-009 SHALL have port pause  input  1  level, freezes tempo while high.
REQ-010 SHALL have port loop_en  input  1  wrap LAST_CROTCHET to 0 instead of finishing.
REQ-011 SHALL have port tempo_inc  input  PHASE_W  phase increment added per frame.
REQ-012 SHALL have port crotchet  output  7  current crotchet index.
REQ-013 SHALL have port crotchet_pulse  output  1  one-cycle pulse when crotchet takes a new play value.
REQ-014 SHALL have port count_in_pulse  output  1  one-cycle pulse per count-in beat.
REQ-015 SHALL have ports running (state COUNT_IN or PLAY) and done (state DONE), output, 1 each.

Function
REQ-016 SHALL implement states IDLE, COUNT_IN, PLAY, DONE; all outputs registered.
REQ-017 SHALL, in COUNT_IN/PLAY with frame_pulse=1 and pause=0, update acc <= (acc + tempo_inc) mod 2^PHASE_W; carry-out is a beat event.
REQ-018 SHALL ignore frame_pulse in IDLE, DONE, or while pause=1 (acc, counters, crotchet hold).
REQ-019 SHALL, in IDLE or DONE with start=1, clear acc, set crotchet=0, and go to COUNT_IN (COUNT_IN_BEATS>0) or PLAY (COUNT_IN_BEATS=0).
REQ-020 SHALL, on direct entry to PLAY from start, assert crotchet_pulse with crotchet=0 in the cycle after start is sampled.
REQ-021 SHALL, in COUNT_IN, assert count_in_pulse for beat events 1..COUNT_IN_BEATS; beat event COUNT_IN_BEATS+1 enters PLAY and asserts crotchet_pulse with crotchet=0.
REQ-022 SHALL, in PLAY on a beat event with crotchet<LAST_CROTCHET, increment crotchet and assert crotchet_pulse.
REQ-023 SHALL, in PLAY on a beat event with crotchet=LAST_CROTCHET: loop_en=1 -> crotchet=0 with crotchet_pulse; loop_en=0 -> DONE, no pulse, crotchet holds LAST_CROTCHET.
REQ-024 SHALL update crotchet in the same cycle crotchet_pulse is high, one cycle after the causing frame_pulse/start.
REQ-025 SHALL give stop priority over start, beat events and pause: next cycle IDLE, crotchet=0, acc=0, count cleared, no pulses.
REQ-026 SHALL ignore start while in COUNT_IN or PLAY.
REQ-027 SHALL, with tempo_inc=0, produce no beat events (sequence stalls, no error).
REQ-028 SHALL never assert crotchet_pulse and count_in_pulse in the same cycle; each pulse lasts exactly one cycle.

Reset
REQ-029 SHALL, while rst_n=0, immediately force state=IDLE, acc=0, count-in counter=0, crotchet=0, crotchet_pulse=0, count_in_pulse=0, running=0, done=0.
REQ-030 SHALL, on reset mid-sequence, discard all progress; first activity after release requires start.

Verification
REQ-031 SHALL cover: tempo_inc=0x800, COUNT_IN_BEATS=4, start -> count_in_pulse on frames 2,4,6,8; crotchet_pulse crotchet=0 on frame 10, crotchet=1 on frame 12.
REQ-032 SHALL cover: loop_en=0, play to crotchet=103, next beat -> done=1, running=0, crotchet=103, no pulse; start -> crotchet=0 restarts.
REQ-033 SHALL cover: loop_en=1 at crotchet=103, next beat -> crotchet=0 with crotchet_pulse=1, running stays 1.
REQ-034 SHALL cover: pause=1 for 10 frame_pulses in PLAY at crotchet=5 -> crotchet stays 5, no pulses; release resumes with acc unchanged.
REQ-035 SHALL cover: stop and beat event same cycle at crotchet=20 -> next cycle IDLE, crotchet=0, no crotchet_pulse.
REQ-036 SHALL cover: rst_n low asynchronously mid-PLAY (crotchet=40) -> outputs zero before next clk edge; tempo_inc=0 after start -> no pulses for 100 frames.
